// File: rtl/cordic_fixed_to_float_if.sv
// cordic_fixed_to_float_if
//   Handshake bundle between the CORDIC core output and the fixed-to-float
//   return stage.
//   clk_en  : global enable; when low the converter freezes completely
//   start   : conversion request, sampled only while the converter is idle
//   data_in : signed fixed-point value, captured on the edge accepting start
//   result  : IEEE-754 single-precision result, registered
//   done    : single-cycle completion pulse
//   busy    : high whenever the converter is not idle
//   master  : upstream side (drives clk_en/start/data_in)
//   slave   : converter side (drives result/done/busy)
interface cordic_fixed_to_float_if #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int CRD_DATA_WIDTH = 22
);
  logic                      clk_en;
  logic                      start;
  logic [CRD_DATA_WIDTH-1:0] data_in;
  logic [FLT_DATA_WIDTH-1:0] result;
  logic                      done;
  logic                      busy;

  modport master (
    output clk_en, start, data_in,
    input  result, done, busy
  );

  modport slave (
    input  clk_en, start, data_in,
    output result, done, busy
  );
endinterface

// File: rtl/cordic_fixed_to_float.sv
// cordic_fixed_to_float
//   Converts a signed two's-complement fixed-point CORDIC result (default
//   Q2.20) into an IEEE-754 single-precision float. Normalisation shifts the
//   magnitude left one bit per enabled cycle until its MSB is set, so no
//   floating-point IP is needed and no rounding ever occurs.
//
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous, active-low reset
//     bus : cordic_fixed_to_float_if.slave (clk_en, start, data_in in;
//           result, done, busy out)
//
//   Optional feature macro: FX2FP_SCALE_EN
//     When defined, SCALE_EXP is added to the exponent of non-zero results,
//     undoing the power-of-two pre-scaling of the forward path. The exponent
//     saturates at 254 (mantissa kept) and flushes to +0 when <= 0.
//     When undefined, SCALE_EXP is unused and no adjustment logic exists.
module cordic_fixed_to_float #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int CRD_DATA_WIDTH = 22,
  parameter int FRAC_BITS      = 20,
  parameter int EXP_BIAS       = 127,
  parameter int COUNTER_WIDTH  = 5,
  parameter int SCALE_EXP      = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  cordic_fixed_to_float_if.slave   bus
);

  localparam int W        = CRD_DATA_WIDTH;
  // Exponent of a value whose MSB sits at bit W-1 (lz = 0).
  localparam int EXP_BASE = EXP_BIAS + W - 1 - FRAC_BITS;

  // Reject parameter sets the datapath cannot represent exactly.
  if ((W - 1) > 23 || (1 << COUNTER_WIDTH) <= W || FLT_DATA_WIDTH != 32 ||
      SCALE_EXP > 254 || SCALE_EXP < -254) begin : g_param_check
    $error("cordic_fixed_to_float: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  state_t                    state;
  logic                      sign_reg;
  logic [W-1:0]              mag_reg;
  logic [COUNTER_WIDTH-1:0]  lz_reg;
  logic [FLT_DATA_WIDTH-1:0] result_reg;
  logic                      done_reg;
  logic                      busy_reg;

  localparam logic [W-1:0] MAG_ONE = W'(1);

  // Magnitude of the input as a W-bit unsigned value; -2^(W-1) maps to
  // 2^(W-1), which still fits.
  logic [W-1:0] abs_in;
  assign abs_in = bus.data_in[W-1] ? ((~bus.data_in) + MAG_ONE) : bus.data_in;

  // Signed exponent intermediate, wide enough for any lz and scale offset.
  logic signed [11:0] exp_calc;
  assign exp_calc = $signed(12'(EXP_BASE)) - $signed(12'(lz_reg));

  // Fraction below the (dropped) implicit leading one, left-aligned in 23 bits.
  logic [22:0] mant_bits;
  assign mant_bits = 23'(mag_reg[W-2:0]) << (24 - W);

  logic [FLT_DATA_WIDTH-1:0] packed_word;

`ifdef FX2FP_SCALE_EN
  logic signed [11:0] exp_scaled;
  assign exp_scaled = exp_calc + $signed(12'(SCALE_EXP));

  always_comb begin
    packed_word = '0;
    if (mag_reg != '0) begin
      if (exp_scaled <= 0)
        packed_word = '0;
      else if (exp_scaled > 254)
        packed_word = {sign_reg, 8'd254, mant_bits};
      else
        packed_word = {sign_reg, exp_scaled[7:0], mant_bits};
    end
  end
`else
  // Upper exponent bits are never non-zero for legal parameter sets.
  logic unused_exp_hi;
  assign unused_exp_hi = ^exp_calc[11:8];

  always_comb begin
    packed_word = '0;
    if (mag_reg != '0)
      packed_word = {sign_reg, exp_calc[7:0], mant_bits};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sign_reg   <= 1'b0;
      mag_reg    <= '0;
      lz_reg     <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else if (bus.clk_en) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sign_reg <= bus.data_in[W-1];
            mag_reg  <= abs_in;
            lz_reg   <= '0;
            busy_reg <= 1'b1;
            state    <= NORM;
          end
        end
        NORM: begin
          // Zero never normalises; it is packed as +0 with lz left at 0.
          if (mag_reg == '0 || mag_reg[W-1]) begin
            state <= PACK;
          end else begin
            mag_reg <= mag_reg << 1;
            lz_reg  <= lz_reg + COUNTER_WIDTH'(1);
          end
        end
        PACK: begin
          result_reg <= packed_word;
          done_reg   <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.done   = done_reg;
  assign bus.busy   = busy_reg;

endmodule

// File: tb/tb_cordic_fixed_to_float.sv
// tb_cordic_fixed_to_float
//   Directed and randomized checks of the fixed-to-float return stage against
//   a reference model that derives the float from the real value of the input
//   (MSB position of the magnitude, plain integer arithmetic). Build with
//   +define+FX2FP_SCALE_EN to exercise the scaled-exponent variant.
module tb_cordic_fixed_to_float;

  localparam int W         = 22;
  localparam int SCALE_EXP = 7;

  logic clk;
  logic rst;

  cordic_fixed_to_float_if #(.FLT_DATA_WIDTH(32), .CRD_DATA_WIDTH(W)) bus ();

  cordic_fixed_to_float #(
    .FLT_DATA_WIDTH(32),
    .CRD_DATA_WIDTH(W),
    .FRAC_BITS(20),
    .EXP_BIAS(127),
    .COUNTER_WIDTH(5),
    .SCALE_EXP(SCALE_EXP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total;
  int          n_pass;
  logic [31:0] prev_result;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Value = signed(d) * 2^-20; float = 1.f * 2^e with e the MSB index of the
  // magnitude scaled by 2^-20.
  function automatic logic [31:0] ref_float(input logic [W-1:0] d);
    longint v;
    longint m;
    int     e;
    int     expo;
    logic [22:0] frac;
    v = longint'($signed(d));
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    expo = 127 + e - 20;
`ifdef FX2FP_SCALE_EN
    expo = expo + SCALE_EXP;
    if (expo <= 0) return 32'h0;
    if (expo > 254) expo = 254;
`endif
    frac = 23'((m << (23 - e)) & 64'h7FFFFF);
    return {(v < 0), 8'(expo), frac};
  endfunction

  // Enabled edges from the accepting edge to the PACK edge.
  function automatic int ref_latency(input logic [W-1:0] d);
    longint v;
    longint m;
    int     e;
    v = longint'($signed(d));
    if (v == 0) return 2;
    m = (v < 0) ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return 2 + (W - 1 - e);
  endfunction

  task automatic convert(input logic [W-1:0] d, input bit toggle_en, input bit hold_start,
                         input logic [31:0] exp_result, input int exp_lat, input string tag);
    int edges;
    int busy_bad;
    bit got;
    bus.data_in = d;
    bus.start   = 1'b1;
    bus.clk_en  = 1'b1;
    @(posedge clk);           // edge 0 accepts start
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    check({tag, "_result_held"}, bus.result, prev_result);
    edges    = 0;
    busy_bad = 0;
    got      = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (!bus.busy) busy_bad++;
        bus.clk_en = toggle_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hold_start) bus.data_in = W'($urandom);
        @(posedge clk);
        if (bus.clk_en) edges++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
    check({tag, "_result"}, bus.result, exp_result);
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    if (toggle_en) begin
      bus.clk_en = 1'b0;      // frozen: done must persist
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_frozen"}, 32'(bus.done), 32'd1);
    end
    bus.clk_en = 1'b1;
    @(posedge clk);           // DONE -> IDLE; held start is not taken here
    @(negedge clk);
    check({tag, "_done_single"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    bus.start   = 1'b0;
    prev_result = exp_result;
    $display("conv %s data_in=%h result=%h latency=%0d", tag, d, bus.result, edges);
  endtask

  logic [W-1:0] dir_data [6];
  logic [31:0]  dir_exp  [6];
  int           dir_lat  [6];

  initial begin
    int done_cnt;
    logic [W-1:0] rd;
    n_total     = 0;
    n_pass      = 0;
    prev_result = 32'h0;

    dir_data = '{22'h100000, 22'h180000, 22'h300000, 22'h200000, 22'h000000, 22'h000001};
`ifdef FX2FP_SCALE_EN
    dir_exp  = '{32'h43000000, 32'h43400000, 32'hC3000000, 32'hC3800000, 32'h00000000, 32'h39000000};
`else
    dir_exp  = '{32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'hC0000000, 32'h00000000, 32'h35800000};
`endif
    dir_lat  = '{3, 3, 3, 2, 2, 23};

    rst         = 1'b1;
    bus.clk_en  = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", bus.result, 32'h0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed values with hand-derived constants; model must agree too.
    for (int i = 0; i < 6; i++) begin
      check($sformatf("model_dir%0d", i), ref_float(dir_data[i]), dir_exp[i]);
      convert(dir_data[i], 1'b0, 1'b0, dir_exp[i], dir_lat[i], $sformatf("dir%0d", i));
    end

    // start held high while clk_en toggles; changing data_in during busy ignored.
    for (int i = 0; i < 4; i++) begin
      rd = W'($urandom) >> $urandom_range(0, 21);
      convert(rd, 1'b1, 1'b1, ref_float(rd), ref_latency(rd), $sformatf("hold%0d", i));
    end

    // Randomized magnitudes and signs.
    for (int i = 0; i < 16; i++) begin
      rd = W'($urandom) >> $urandom_range(0, 21);
      if ($urandom_range(0, 1) == 1) rd = -rd;
      convert(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ref_float(rd), ref_latency(rd), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a long normalisation.
    bus.data_in = 22'h000001;
    bus.start   = 1'b1;
    bus.clk_en  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_result", bus.result, 32'h0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    check("midreset_idle", 32'(bus.busy), 32'd0);
    $display("conv midreset result=%h done_count=%0d", bus.result, done_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cordic_fixed_to_float.md
Name: cordic_fixed_to_float

Overview:
- Return path for the CORDIC datapath. Converts a signed two's-complement fixed-point CORDIC result into an IEEE-754 single-precision float.
- Uses the same start/done handshake style as the float-to-fixed front stage.
- Normalisation is iterative, one bit per cycle, so the block needs no floating-point IP and has no rounding: every input value is exactly representable.
- Sits between the CORDIC core output and the float accumulation stage.

Parameters:
- FLT_DATA_WIDTH, 32: float output width. Fixed at 32.
- CRD_DATA_WIDTH, 22: CORDIC fixed-point width (W). Must satisfy W-1 <= 23.
- FRAC_BITS, 20: fractional bits. Default format is Q2.20, range [-2.0, 2.0).
- EXP_BIAS, 127: IEEE single exponent bias.
- COUNTER_WIDTH, 5: leading-zero counter width. Must satisfy 2^COUNTER_WIDTH > W.
- SCALE_EXP, 7: signed exponent offset. Used only when FX2FP_SCALE_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- clk_en  input  1  when low, the block freezes: FSM, registers and outputs all hold.
- start  input  1  request. Sampled in IDLE only.
- data_in  input  CRD_DATA_WIDTH  signed fixed-point value. Sampled on the edge that accepts start.
- result  output  FLT_DATA_WIDTH  IEEE-754 single. Registered.
- done  output  1  single-cycle completion pulse.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, result=0, done=0, busy=0.
  - Internal sign, mag and lz registers clear to 0.
  - Reset takes effect mid-conversion: the in-flight conversion is abandoned, and no done pulse is produced for it.
- States:
  - IDLE: if start && clk_en, latch sign=data_in[W-1], mag=|data_in| (W-bit unsigned) and lz=0, then go to NORM. Otherwise stay.
  - NORM: if mag==0 or mag[W-1]==1, go to PACK. Otherwise shift mag left by 1, increment lz, and stay.
  - PACK: compute the output word, register it into result, set done=1, go to DONE.
  - DONE: clear done, go to IDLE.
- Packing rules:
  - If mag==0: result=32'h00000000. This is always +0; -0 is never produced.
  - Otherwise:
    - result[31] = sign.
    - Exponent: result[30:23] = EXP_BIAS + (W-1-lz) - FRAC_BITS.
    - Mantissa: result[22:0] = {mag[W-2:0], (24-W) zero bits}. The implicit leading 1 is dropped.
- Most negative input:
  - -2^(W-1) gives mag=2^(W-1); the W-bit unsigned magnitude does not overflow.
  - Result is -2.0 for the default format.
- Latency:
  - Edge 0 is the clk_en-qualified edge that samples start.
  - done is high during the cycle following edge lz+2, where lz is the leading-zero count of mag within W bits.
  - Zero input uses lz=0, so done follows edge 2.
  - Range is 2..W+1 edges.
  - Edges where clk_en=0 are not counted.
- Handshake:
  - done is high for exactly one enabled cycle.
  - result changes only on the PACK edge and holds until the next PACK edge.
  - start is ignored while busy=1; no queueing.
  - start may be re-asserted in the cycle done is high. It is accepted on the DONE→IDLE edge only if it is still high in IDLE.
- Exponent arithmetic uses a signed intermediate of at least 10 bits. With default parameters the exponent lies in 107..128, so there is no under- or overflow.

Optional Feature:
- Macro: FX2FP_SCALE_EN.
- Defined: SCALE_EXP is added to the computed exponent for non-zero inputs; zero stays +0. This undoes the /128 pre-scaling applied on the forward path.
  - The exponent saturates to 254 on overflow, with mantissa kept.
  - The output flushes to +0 if the exponent is <= 0.
- Not defined: no exponent adjustment, no saturation logic, and SCALE_EXP is unused.

Test Plan:
- Reset then idle, with rst pulsed low mid-NORM → result=0, done=0, busy=0 immediately (asynchronous); no done afterwards.
- data_in=22'h100000 (1.0) → result=32'h3F800000; done after edge 3. data_in=22'h180000 (1.5) → 32'h3FC00000.
- data_in=22'h300000 (-1.0) → 32'hBF800000. data_in=22'h200000 (-2.0) → 32'hC0000000; done after edge 2.
- data_in=0 → 32'h00000000; done after edge 2. data_in=22'h000001 (2^-20) → 32'h35800000; done after edge 23.
- start held high continuously while clk_en toggles 0/1:
  - busy stays high throughout each conversion;
  - exactly one done per conversion;
  - latency counts enabled edges only;
  - a second start during busy is ignored.
- FX2FP_SCALE_EN defined, SCALE_EXP=7: data_in=22'h100000 → 32'h43000000 (128.0); data_in=0 → 32'h00000000.
